// File: rtl/control_unit.sv
// control_unit: multicycle CPU sequencer; decodes ir[31:27] with con_ff/stop and drives mem_ctl, gp_ctl, in_ctl, out_ctl, alu_op, run, step
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011,
  parameter logic [4:0] NOP_OP = 5'b11010
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic [1:0]  mem_ctl,
  output logic [5:0]  gp_ctl,
  output logic [10:0] in_ctl,
  output logic [7:0]  out_ctl,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  step
);
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd14, RESET = 4'd15
  } state_t;
  state_t state_q, state_d, fin;
  logic [4:0] op;
  logic t0, t1, t2, t3, t4, t5, t6, t7, last, add_f, ir_unused;
  logic rd, wr, gra, grb, grc, rin, rout, ba_out;
  logic mar_in, mdr_in, hi_in, lo_in, y_in, z_in, pc_in, ir_in, inc_pc, oport_in, conn_in;
  logic hi_out, lo_out, zlo_out, zhi_out, mdr_out, c_out, iport_out, pc_out;
  assign op = ir[31:27];
  assign ir_unused = ^ir[26:0];
  assign {t0, t1, t2, t3, t4, t5, t6, t7} = {state_q == T0, state_q == T1, state_q == T2, state_q == T3,
                                             state_q == T4, state_q == T5, state_q == T6, state_q == T7};
  always_ff @(posedge clk) state_q <= clr ? RESET : state_d;
  always_comb begin
    {rd, wr, gra, grb, grc, rin, rout, ba_out} = '0;
    {mar_in, mdr_in, hi_in, lo_in, y_in, z_in, pc_in, ir_in, inc_pc, oport_in, conn_in} = '0;
    {hi_out, lo_out, zlo_out, zhi_out, mdr_out, c_out, iport_out, pc_out} = '0;
    fin = T2;
    add_f = 1'b0;
    case (op) inside
      [5'd3:5'd11]: begin
        fin = T5;
        grb = t3; rout = t3 | t4; y_in = t3;
        grc = t4; z_in = t4;
        zlo_out = t5; gra = t5; rin = t5;
      end
      [5'd12:5'd14]: begin
        fin = T5;
        grb = t3; rout = t3; y_in = t3;
        c_out = t4; z_in = t4;
        zlo_out = t5; gra = t5; rin = t5;
      end
      [5'd0:5'd2]: begin
        fin = op[0] ? T5 : T7;
        grb = t3; ba_out = t3; y_in = t3;
        c_out = t4; z_in = t4; add_f = t4;
        zlo_out = t5; mar_in = ~op[0] & t5;
        gra = op[0] ? t5 : op[1] ? t6 : t7;
        rin = op[0] ? t5 : ~op[1] & t7;
        rd = ~op[1] & ~op[0] & t6;
        mdr_in = ~op[0] & t6;
        rout = op[1] & t6;
        mdr_out = ~op[1] & ~op[0] & t7;
        wr = op[1] & t7;
      end
      [5'd15:5'd16]: begin
        fin = T6;
        gra = t3; rout = t3 | t4; y_in = t3;
        grb = t4; z_in = t4;
        zlo_out = t5; lo_in = t5;
        zhi_out = t6; hi_in = t6;
      end
      [5'd17:5'd18]: begin
        fin = T4;
        grb = t3; rout = t3; z_in = t3;
        zlo_out = t4; gra = t4; rin = t4;
      end
      5'd19: begin
        fin = T6;
        gra = t3; rout = t3; conn_in = t3;
        pc_out = t4; y_in = t4;
        c_out = t5; z_in = t5; add_f = t5;
        zlo_out = t6 & con_ff; pc_in = t6 & con_ff;
      end
      5'd20: begin
        fin = T3;
        gra = t3; rout = t3; pc_in = t3;
      end
      5'd21: begin
        fin = T4;
        pc_out = t3; grb = t3; rin = t3;
        gra = t4; rout = t4; pc_in = t4;
      end
      5'd22: begin
        fin = T3;
        iport_out = t3; gra = t3; rin = t3;
      end
      5'd23: begin
        fin = T3;
        gra = t3; rout = t3; oport_in = t3;
      end
      5'd24: begin
        fin = T3;
        hi_out = t3; gra = t3; rin = t3;
      end
      5'd25: begin
        fin = T3;
        lo_out = t3; gra = t3; rin = t3;
      end
      default: ;
    endcase
    if (t0) begin
      pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
    end
    if (t1) begin
      zlo_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1;
    end
    if (t2) begin
      mdr_out = 1'b1; ir_in = 1'b1;
    end
    alu_op = (t3 | t4 | t5 | t6 | t7) ? (add_f ? ADD_OP : op) : NOP_OP;
    last = run && state_q >= fin;
    state_d = state_q == RESET ? T0 :
              state_q == HALT ? HALT :
              !last ? state_t'(state_q + 4'd1) :
              (stop || op == 5'd27) ? HALT : T0;
  end
  assign run = state_q <= T7;
  assign step = state_q;
  assign mem_ctl = {rd, wr};
  assign gp_ctl = {gra, grb, grc, rin, rout, ba_out};
  assign in_ctl = {mar_in, mdr_in, hi_in, lo_in, y_in, z_in, pc_in, ir_in, inc_pc, oport_in, conn_in};
  assign out_ctl = {hi_out, lo_out, zlo_out, zhi_out, mdr_out, c_out, iport_out, pc_out};
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven directed checks of the control_unit sequencer
module tb_control_unit;
  logic clk = 1'b0, clr, con_ff, stop;
  logic [31:0] ir;
  logic [1:0] mem_ctl;
  logic [5:0] gp_ctl;
  logic [10:0] in_ctl;
  logic [7:0] out_ctl;
  logic [4:0] alu_op;
  logic run;
  logic [3:0] step;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .mem_ctl(mem_ctl), .gp_ctl(gp_ctl), .in_ctl(in_ctl), .out_ctl(out_ctl),
    .alu_op(alu_op), .run(run), .step(step)
  );
  localparam logic [1:0] RD = 2'b10, WR = 2'b01;
  localparam logic [5:0] GRA = 6'h20, GRB = 6'h10, GRC = 6'h08, RIN = 6'h04, ROUT = 6'h02, BAOUT = 6'h01;
  localparam logic [10:0] MARIN = 11'h400, MDRIN = 11'h200, HIIN = 11'h100, LOIN = 11'h080, YIN = 11'h040,
                          ZIN = 11'h020, PCIN = 11'h010, IRIN = 11'h008, INCPC = 11'h004, CONIN = 11'h001;
  localparam logic [7:0] HIO = 8'h80, ZLO = 8'h20, ZHI = 8'h10, MDRO = 8'h08, CO = 8'h04, PCO = 8'h01;
  localparam logic [4:0] ADD = 5'b00011, NOP = 5'b11010;
  localparam logic [31:0] ADD_IR = 32'h18918000, LD_IR = 32'h00800055, LDI_IR = 32'h08800055,
                          ST_IR = 32'h10800055, BR_IR = 32'h98000000, MUL_IR = 32'h78000000,
                          NEG_IR = 32'h88000000, JAL_IR = 32'hA8000000, MFHI_IR = 32'hC0000000,
                          ADDI_IR = 32'h60000000, NOP_IR = 32'hD0000000, UND_IR = 32'hF8000000,
                          HALT_IR = 32'hD8000000;
  typedef struct {
    string n;
    logic c;
    logic [31:0] i;
    logic cf;
    logic sp;
    logic [3:0] st;
    logic [1:0] m;
    logic [5:0] g;
    logic [10:0] x;
    logic [7:0] o;
    logic [4:0] a;
    logic r;
  } vec_t;
  vec_t q[$];
  int checks = 0, errors = 0;
  task automatic put(input string n, input logic c, input logic [31:0] i, input logic cf, input logic sp,
                     input logic [3:0] st, input logic [1:0] m, input logic [5:0] g, input logic [10:0] x,
                     input logic [7:0] o, input logic [4:0] a, input logic r);
    vec_t v;
    v.n = n; v.c = c; v.i = i; v.cf = cf; v.sp = sp; v.st = st;
    v.m = m; v.g = g; v.x = x; v.o = o; v.a = a; v.r = r;
    q.push_back(v);
  endtask
  task automatic fetch(input string n, input logic [31:0] i, input logic sp = 1'b0);
    put({n, ".T0"}, 1'b0, i, 1'b0, sp, 4'd0, 2'b00, 6'h00, MARIN | INCPC | ZIN, PCO, NOP, 1'b1);
    put({n, ".T1"}, 1'b0, i, 1'b0, sp, 4'd1, RD, 6'h00, PCIN | MDRIN, ZLO, NOP, 1'b1);
    put({n, ".T2"}, 1'b0, i, 1'b0, sp, 4'd2, 2'b00, 6'h00, IRIN, MDRO, NOP, 1'b1);
  endtask
  task automatic ex(input string n, input logic [31:0] i, input logic [3:0] st, input logic [1:0] m,
                    input logic [5:0] g, input logic [10:0] x, input logic [7:0] o, input logic [4:0] a,
                    input logic cf = 1'b0, input logic sp = 1'b0);
    put(n, 1'b0, i, cf, sp, st, m, g, x, o, a, 1'b1);
  endtask
  task automatic idle(input string n, input logic c, input logic [3:0] st);
    put(n, c, 32'h0, 1'b0, 1'b0, st, 2'b00, 6'h00, 11'h000, 8'h00, NOP, 1'b0);
  endtask
  task automatic apply(input vec_t v);
    clr = v.c; ir = v.i; con_ff = v.cf; stop = v.sp;
    #1;
    checks++;
    if ({step, mem_ctl, gp_ctl, in_ctl, out_ctl, alu_op, run} !== {v.st, v.m, v.g, v.x, v.o, v.a, v.r}) begin
      errors++;
      $display("FAIL %s: got step=%0d mem=%b gp=%b in=%b out=%b alu=%b run=%b, want step=%0d mem=%b gp=%b in=%b out=%b alu=%b run=%b",
               v.n, step, mem_ctl, gp_ctl, in_ctl, out_ctl, alu_op, run, v.st, v.m, v.g, v.x, v.o, v.a, v.r);
    end
    checks++;
    if (mem_ctl === 2'b11) begin
      errors++;
      $display("FAIL %s.rw_excl: got mem=%b, want read and write not both set", v.n, mem_ctl);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic flush;
    while (q.size() > 0) apply(q.pop_front());
  endtask
  initial begin
    clr = 1'b1; ir = 32'h0; con_ff = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle("reset", 1'b0, 4'd15);
    fetch("add", ADD_IR);
    ex("add.T3", ADD_IR, 4'd3, 2'b00, GRB | ROUT, YIN, 8'h00, ADD);
    ex("add.T4", ADD_IR, 4'd4, 2'b00, GRC | ROUT, ZIN, 8'h00, ADD);
    ex("add.T5", ADD_IR, 4'd5, 2'b00, GRA | RIN, 11'h000, ZLO, ADD);
    fetch("ld", LD_IR);
    ex("ld.T3", LD_IR, 4'd3, 2'b00, GRB | BAOUT, YIN, 8'h00, 5'd0);
    ex("ld.T4", LD_IR, 4'd4, 2'b00, 6'h00, ZIN, CO, ADD);
    ex("ld.T5", LD_IR, 4'd5, 2'b00, 6'h00, MARIN, ZLO, 5'd0);
    ex("ld.T6", LD_IR, 4'd6, RD, 6'h00, MDRIN, 8'h00, 5'd0);
    ex("ld.T7", LD_IR, 4'd7, 2'b00, GRA | RIN, 11'h000, MDRO, 5'd0);
    fetch("ldi", LDI_IR);
    ex("ldi.T3", LDI_IR, 4'd3, 2'b00, GRB | BAOUT, YIN, 8'h00, 5'd1);
    ex("ldi.T4", LDI_IR, 4'd4, 2'b00, 6'h00, ZIN, CO, ADD);
    ex("ldi.T5", LDI_IR, 4'd5, 2'b00, GRA | RIN, 11'h000, ZLO, 5'd1);
    fetch("st", ST_IR);
    ex("st.T3", ST_IR, 4'd3, 2'b00, GRB | BAOUT, YIN, 8'h00, 5'd2);
    ex("st.T4", ST_IR, 4'd4, 2'b00, 6'h00, ZIN, CO, ADD);
    ex("st.T5", ST_IR, 4'd5, 2'b00, 6'h00, MARIN, ZLO, 5'd2);
    ex("st.T6", ST_IR, 4'd6, 2'b00, GRA | ROUT, MDRIN, 8'h00, 5'd2);
    ex("st.T7", ST_IR, 4'd7, WR, 6'h00, 11'h000, 8'h00, 5'd2);
    fetch("br1", BR_IR);
    ex("br1.T3", BR_IR, 4'd3, 2'b00, GRA | ROUT, CONIN, 8'h00, 5'd19, 1'b1);
    ex("br1.T4", BR_IR, 4'd4, 2'b00, 6'h00, YIN, PCO, 5'd19, 1'b1);
    ex("br1.T5", BR_IR, 4'd5, 2'b00, 6'h00, ZIN, CO, ADD, 1'b1);
    ex("br1.T6", BR_IR, 4'd6, 2'b00, 6'h00, PCIN, ZLO, 5'd19, 1'b1);
    fetch("br0", BR_IR);
    ex("br0.T3", BR_IR, 4'd3, 2'b00, GRA | ROUT, CONIN, 8'h00, 5'd19);
    ex("br0.T4", BR_IR, 4'd4, 2'b00, 6'h00, YIN, PCO, 5'd19);
    ex("br0.T5", BR_IR, 4'd5, 2'b00, 6'h00, ZIN, CO, ADD);
    ex("br0.T6", BR_IR, 4'd6, 2'b00, 6'h00, 11'h000, 8'h00, 5'd19);
    fetch("mul", MUL_IR);
    ex("mul.T3", MUL_IR, 4'd3, 2'b00, GRA | ROUT, YIN, 8'h00, 5'd15);
    ex("mul.T4", MUL_IR, 4'd4, 2'b00, GRB | ROUT, ZIN, 8'h00, 5'd15);
    ex("mul.T5", MUL_IR, 4'd5, 2'b00, 6'h00, LOIN, ZLO, 5'd15);
    ex("mul.T6", MUL_IR, 4'd6, 2'b00, 6'h00, HIIN, ZHI, 5'd15);
    fetch("neg", NEG_IR);
    ex("neg.T3", NEG_IR, 4'd3, 2'b00, GRB | ROUT, ZIN, 8'h00, 5'd17);
    ex("neg.T4", NEG_IR, 4'd4, 2'b00, GRA | RIN, 11'h000, ZLO, 5'd17);
    fetch("jal", JAL_IR);
    ex("jal.T3", JAL_IR, 4'd3, 2'b00, GRB | RIN, 11'h000, PCO, 5'd21);
    ex("jal.T4", JAL_IR, 4'd4, 2'b00, GRA | ROUT, PCIN, 8'h00, 5'd21);
    fetch("mfhi", MFHI_IR);
    ex("mfhi.T3", MFHI_IR, 4'd3, 2'b00, GRA | RIN, 11'h000, HIO, 5'd24);
    fetch("addi", ADDI_IR);
    ex("addi.T3", ADDI_IR, 4'd3, 2'b00, GRB | ROUT, YIN, 8'h00, 5'd12);
    ex("addi.T4", ADDI_IR, 4'd4, 2'b00, 6'h00, ZIN, CO, 5'd12);
    ex("addi.T5", ADDI_IR, 4'd5, 2'b00, GRA | RIN, 11'h000, ZLO, 5'd12);
    fetch("nop", NOP_IR);
    fetch("undef", UND_IR);
    fetch("halt", HALT_IR);
    flush();
    for (int k = 0; k < 20; k++) idle("halt.hold", 1'b0, 4'd14);
    idle("halt.clr", 1'b1, 4'd14);
    idle("halt.reset", 1'b0, 4'd15);
    flush();
    fetch("stop", ADD_IR, 1'b1);
    ex("stop.T3", ADD_IR, 4'd3, 2'b00, GRB | ROUT, YIN, 8'h00, ADD, 1'b0, 1'b1);
    ex("stop.T4", ADD_IR, 4'd4, 2'b00, GRC | ROUT, ZIN, 8'h00, ADD, 1'b0, 1'b1);
    ex("stop.T5", ADD_IR, 4'd5, 2'b00, GRA | RIN, 11'h000, ZLO, ADD, 1'b0, 1'b1);
    idle("stop.halt", 1'b1, 4'd14);
    idle("stop.reset", 1'b0, 4'd15);
    flush();
    fetch("ldrst", LD_IR);
    ex("ldrst.T3", LD_IR, 4'd3, 2'b00, GRB | BAOUT, YIN, 8'h00, 5'd0);
    ex("ldrst.T4", LD_IR, 4'd4, 2'b00, 6'h00, ZIN, CO, ADD);
    put("ldrst.T5", 1'b1, LD_IR, 1'b0, 1'b0, 4'd5, 2'b00, 6'h00, MARIN, ZLO, 5'd0, 1'b1);
    idle("ldrst.r1", 1'b1, 4'd15);
    idle("ldrst.r2", 1'b1, 4'd15);
    idle("ldrst.r3", 1'b0, 4'd15);
    fetch("after", ADD_IR);
    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
